// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fetch_queue_pkg : shared CPU types for the F2->decode instruction queue   |
// | Rev 1.0                                                                   |
// +-------------------------------------------------------------------------+
package fetch_queue_pkg;

  localparam int FETCH_QUEUE_DEPTH = 8;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [1:0]  excp;   // bit0 misaligned, bit1 access fault
  } fetch_entry_t;

endpackage : fetch_queue_pkg
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fetch_queue_if : push (F2) and head (decode) signals of the fetch queue    |
// | Rev 1.0                                                                   |
// +-------------------------------------------------------------------------+
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [63:0]   in_pc;
  logic [31:0]   in_instr;
  logic [1:0]    in_excp;
  logic          in_ready;
  logic          almost_full;
  logic          out_valid;
  logic [63:0]   out_pc;
  logic [31:0]   out_instr;
  logic [1:0]    out_excp;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_pc, in_instr, in_excp,
    input  in_ready, almost_full, out_valid, out_pc, out_instr, out_excp, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_excp,
    output in_ready, almost_full, out_valid, out_pc, out_instr, out_excp, count
  );

endinterface : fetch_queue_if
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fetch_queue : circular instruction queue between fetch F2 and decode      |
// | Rev 1.0                                                                   |
// +-------------------------------------------------------------------------+
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH    = FETCH_QUEUE_DEPTH,
  parameter int AF_SLACK = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_que,
  input  logic          stallD,
  fetch_queue_if.slave  fq
);

  localparam int            PW      = $clog2(DEPTH) + 1;
  localparam int            AW      = PW - 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] SLACK_C = PW'(AF_SLACK);

  fetch_entry_t  mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] count_q, count_d;

  logic          in_ready;
  logic          out_valid;
  logic          push_en;
  logic          pop_en;
  fetch_entry_t  in_entry;
  fetch_entry_t  head_entry;

  // Handshake outputs depend on registered state only, so they stay
  // meaningful (pre-flush values) during a flush cycle.
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);

  always_comb begin
    in_entry       = '0;
    in_entry.pc    = fq.in_pc;
    in_entry.instr = fq.in_instr;
    in_entry.excp  = fq.in_excp;

    push_en = fq.in_valid && in_ready && !flush_que;
    pop_en  = out_valid && !stallD && !flush_que;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_que) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) tail_d = tail_q + PW'(1);
      if (pop_en)  head_d = head_q + PW'(1);
      count_d = count_q + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};
    end

    head_entry = out_valid ? mem[head_q[AW-1:0]] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is left unreset; out_* is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push_en) mem[tail_q[AW-1:0]] <= in_entry;
  end

  assign fq.in_ready    = in_ready;
  assign fq.almost_full = ((DEPTH_C - count_q) <= SLACK_C);
  assign fq.out_valid   = out_valid;
  assign fq.out_pc      = head_entry.pc;
  assign fq.out_instr   = head_entry.instr;
  assign fq.out_excp    = head_entry.excp;
  assign fq.count       = count_q;

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_fetch_queue : self-checking bench for fetch_queue against a FIFO model |
// | Rev 1.0                                                                   |
// +-------------------------------------------------------------------------+
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH    = 8;
  localparam int AF_SLACK = 2;

  logic clk;
  logic reset;
  logic flush_que;
  logic stallD;

  int vectors;
  int miscompares;

  fetch_entry_t model[$];

  fetch_queue_if #(.DEPTH(DEPTH)) qif ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .AF_SLACK (AF_SLACK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush_que (flush_que),
    .stallD    (stallD),
    .fq        (qif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    fetch_entry_t exp_head;
    int           n;
    n        = model.size();
    exp_head = (n != 0) ? model[0] : '0;
    chk({tag, ".count"},       64'(qif.count),       64'(n));
    chk({tag, ".out_valid"},   64'(qif.out_valid),   64'(n != 0));
    chk({tag, ".in_ready"},    64'(qif.in_ready),    64'(n < DEPTH));
    chk({tag, ".almost_full"}, 64'(qif.almost_full), 64'((DEPTH - n) <= AF_SLACK));
    chk({tag, ".out_pc"},      qif.out_pc,           exp_head.pc);
    chk({tag, ".out_instr"},   64'(qif.out_instr),   64'(exp_head.instr));
    chk({tag, ".out_excp"},    64'(qif.out_excp),    64'(exp_head.excp));
  endtask

  // One clock: drive at the falling edge, update the model at the rising
  // edge from the pre-edge occupancy, compare 1 ns later.
  task automatic cyc(input string tag, input logic v, input logic [63:0] pc,
                     input logic [31:0] ins, input logic [1:0] ex,
                     input logic st, input logic fl);
    fetch_entry_t e;
    logic         do_push, do_pop;
    @(negedge clk);
    qif.in_valid = v;
    qif.in_pc    = pc;
    qif.in_instr = ins;
    qif.in_excp  = ex;
    stallD       = st;
    flush_que    = fl;
    e.pc    = pc;
    e.instr = ins;
    e.excp  = ex;
    do_push = v && (model.size() < DEPTH) && !fl;
    do_pop  = (model.size() != 0) && !st && !fl;
    @(posedge clk);
    if (fl) model.delete();
    else begin
      if (do_pop)  void'(model.pop_front());
      if (do_push) model.push_back(e);
    end
    #1 check_state(tag);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    flush_que    = 1'b0;
    stallD       = 1'b0;
    qif.in_valid = 1'b0;
    qif.in_pc    = '0;
    qif.in_instr = '0;
    qif.in_excp  = '0;
    repeat (2) @(negedge clk);
    check_state("reset");
    reset = 1'b0;

    // Single push then pop
    cyc("push1", 1'b1, 64'h8000_0000, 32'h0000_0013, 2'b00, 1'b0, 1'b0);
    chk("push1.pc_abs", qif.out_pc, 64'h8000_0000);
    cyc("pop1", 1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
    chk("pop1.valid_abs", 64'(qif.out_valid), 64'd0);

    // Fill with decode stalled, then a held 9th push
    for (int i = 0; i < DEPTH; i++)
      cyc("fill", 1'b1, 64'h1000 + 64'(i * 4), 32'hA000 + 32'(i), 2'(i), 1'b1, 1'b0);
    chk("fill.count_abs", 64'(qif.count), 64'd8);
    cyc("held9", 1'b1, 64'h2000, 32'hBEEF, 2'b00, 1'b1, 1'b0);
    // Full with simultaneous pop: push still rejected
    cyc("full_pp", 1'b1, 64'h2000, 32'hBEEF, 2'b00, 1'b0, 1'b0);
    chk("full_pp.count_abs", 64'(qif.count), 64'd7);
    cyc("accept9", 1'b1, 64'h2000, 32'hBEEF, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      cyc("drain", 1'b0, '0, '0, 2'b00, 1'b0, 1'b0);

    // Flush beats a same-cycle push and pop
    for (int i = 0; i < 5; i++)
      cyc("pre_flush", 1'b1, 64'h3000 + 64'(i), 32'(i), 2'b10, 1'b1, 1'b0);
    cyc("flush", 1'b1, 64'hDEAD, 32'hDEAD, 2'b00, 1'b0, 1'b1);
    chk("flush.valid_abs", 64'(qif.out_valid), 64'd0);

    // Interleaved traffic wrapping the pointers, one misaligned-tagged entry
    for (int i = 0; i < 24; i++)
      cyc("wrap", 1'b1, 64'h4000 + 64'(i * 4), 32'h13 + 32'(i),
          (i == 5) ? 2'b01 : 2'b00, (i % 3) == 0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++)
      cyc("wrap_drain", 1'b0, '0, '0, 2'b00, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 300; i++)
      cyc("rand", $urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom,
          2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
          $urandom_range(0, 40) == 0);

    // Asynchronous reset between edges with entries queued
    cyc("pre_rst", 1'b0, '0, '0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc("pre_rst", 1'b1, 64'h5000 + 64'(i), 32'(i), 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    qif.in_valid = 1'b0;
    flush_que    = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst.count_abs", 64'(qif.count), 64'd0);
    chk("async_rst.valid_abs", 64'(qif.out_valid), 64'd0);
    model.delete();
    check_state("async_rst");
    @(negedge clk);
    reset = 1'b0;
    cyc("post_rst", 1'b1, 64'h6000, 32'h6666, 2'b00, 1'b0, 1'b0);
    cyc("post_rst_pop", 1'b0, '0, '0, 2'b00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fetch_queue
`default_nettype wire
